// File: rtl/psum_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : psum_accum_ctrl
// Description : Partial-sum accumulation controller. It accepts partial sums
//               from the PE array. Each partial sum is either written directly
//               to the output memory (first pass) or added to the stored value
//               with a read-modify-write (accumulate pass). Outstanding reads
//               are kept in an ordered queue. A new accumulate request is
//               stalled while a read to the same address is still in flight.
// Ports       : clk, rst_n                - clock, asynchronous active-low reset
//               in_psum/in_addr/in_first  - request payload
//               in_vld/in_rdy             - request handshake
//               psumctrl_radd/rden        - read request to the decoder
//               psumctrl_odat/ovld        - in-order read return from the decoder
//               psumctrl_wadd/wren/wdat   - write request to the decoder
//               busy                      - reads outstanding or write in flight
//               err_ovld                  - sticky: read data arrived with no
//                                           read outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module psum_accum_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PEND_DEPTH = 4,
  parameter int PEND_WIDTH = 2,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_psum,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_first,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [ADDR_WIDTH-1:0] psumctrl_radd,
  output logic                  psumctrl_rden,
  input  logic [DATA_WIDTH-1:0] psumctrl_odat,
  input  logic                  psumctrl_ovld,
  output logic [ADDR_WIDTH-1:0] psumctrl_wadd,
  output logic                  psumctrl_wren,
  output logic [DATA_WIDTH-1:0] psumctrl_wdat,
  output logic                  busy,
  output logic                  err_ovld
);

  localparam logic [PEND_WIDTH:0]   c_depth   = (PEND_WIDTH+1)'(PEND_DEPTH);
  localparam logic [PEND_WIDTH:0]   c_cnt_one = (PEND_WIDTH+1)'(1);
  localparam logic [PEND_WIDTH-1:0] c_ptr_one = PEND_WIDTH'(1);

  // Pending-read queue storage. This is payload only; validity is given by
  // the pointers and the count, so the storage needs no reset.
  logic [ADDR_WIDTH-1:0] r_q_addr [PEND_DEPTH];
  logic [DATA_WIDTH-1:0] r_q_psum [PEND_DEPTH];
  logic [PEND_WIDTH-1:0] r_wr_ptr;
  logic [PEND_WIDTH-1:0] r_rd_ptr;
  logic [PEND_WIDTH:0]   r_cnt;

  logic [PEND_DEPTH-1:0] w_hit;
  logic                  w_hazard;
  logic                  w_full;
  logic                  w_push;
  logic                  w_first_wr;
  logic                  w_pop;
  logic [DATA_WIDTH:0]   w_sum_ext;
  logic [DATA_WIDTH-1:0] w_sum;

  // Address-hazard detection. A slot is live when its distance from the read
  // pointer is below the count. The head being popped this cycle still
  // counts as live, so its write is issued before a dependent read.
  generate
    for (genvar j = 0; j < PEND_DEPTH; j++) begin : g_slot
      logic [PEND_WIDTH-1:0] w_off;
      assign w_off    = PEND_WIDTH'(j) - r_rd_ptr;
      assign w_hit[j] = ({1'b0, w_off} < r_cnt) && (r_q_addr[j] == in_addr);
    end
  endgenerate

  assign w_hazard = |w_hit;
  assign w_full   = (r_cnt == c_depth);

  // A first-pass write waits for an empty queue. This keeps a first-pass
  // write from colliding with a writeback on the single write port.
  assign in_rdy     = in_first ? (r_cnt == '0) : (!w_full && !w_hazard);
  assign w_push     = in_vld && in_rdy && !in_first;
  assign w_first_wr = in_vld && in_rdy &&  in_first;
  assign w_pop      = psumctrl_ovld && (r_cnt != '0);

  // Signed add at one extra bit. The top two bits of the sum differ
  // exactly when the DATA_WIDTH-bit result overflows.
  assign w_sum_ext = {psumctrl_odat[DATA_WIDTH-1], psumctrl_odat}
                   + {r_q_psum[r_rd_ptr][DATA_WIDTH-1], r_q_psum[r_rd_ptr]};

  generate
    if (SATURATE != 0) begin : g_sat
      logic w_ovf;
      assign w_ovf = w_sum_ext[DATA_WIDTH] ^ w_sum_ext[DATA_WIDTH-1];
      always_comb begin
        w_sum = w_sum_ext[DATA_WIDTH-1:0];
        if (w_ovf) begin
          w_sum = w_sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                        : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
      end
    end else begin : g_wrap
      assign w_sum = w_sum_ext[DATA_WIDTH-1:0];
    end
  endgenerate

  // Queue payload write.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= in_addr;
      r_q_psum[r_wr_ptr] <= in_psum;
    end
  end

  // Queue control. A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_cnt_one;
        2'b01:   r_cnt <= r_cnt - c_cnt_one;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Registered decoder interface. Enables pulse for one cycle. Addresses and
  // data keep their last values between transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psumctrl_rden <= 1'b0;
      psumctrl_radd <= '0;
      psumctrl_wren <= 1'b0;
      psumctrl_wadd <= '0;
      psumctrl_wdat <= '0;
      err_ovld      <= 1'b0;
    end else begin
      psumctrl_rden <= w_push;
      if (w_push) psumctrl_radd <= in_addr;

      psumctrl_wren <= w_first_wr || w_pop;
      if (w_first_wr) begin
        psumctrl_wadd <= in_addr;
        psumctrl_wdat <= in_psum;
      end else if (w_pop) begin
        psumctrl_wadd <= r_q_addr[r_rd_ptr];
        psumctrl_wdat <= w_sum;
      end

      if (psumctrl_ovld && (r_cnt == '0)) err_ovld <= 1'b1;
    end
  end

  assign busy = (r_cnt != '0) || psumctrl_rden || psumctrl_wren;

endmodule
`default_nettype wire

// File: tb/tb_psum_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_accum_ctrl
// Description : Self-checking bench for psum_accum_ctrl. A behavioural model
//               of the pending queue predicts every output on every cycle. A
//               decoder/memory responder returns read data in order. A second
//               instance built with wrap-around addition shares all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_accum_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_psum;
  logic [AW-1:0] in_addr;
  logic          in_first;
  logic          in_vld;
  logic          in_rdy;
  logic [AW-1:0] radd;
  logic          rden;
  logic [DW-1:0] odat;
  logic          ovld;
  logic [AW-1:0] wadd;
  logic          wren;
  logic [DW-1:0] wdat;
  logic          busy;
  logic          err;

  logic          w1_rdy;
  logic [AW-1:0] w1_radd;
  logic          w1_rden;
  logic [AW-1:0] w1_wadd;
  logic          w1_wren;
  logic [DW-1:0] w1_wdat;
  logic          w1_busy;
  logic          w1_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psum_accum_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PEND_DEPTH(DEPTH),
                    .PEND_WIDTH(2), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_psum(in_psum), .in_addr(in_addr),
    .in_first(in_first), .in_vld(in_vld), .in_rdy(in_rdy),
    .psumctrl_radd(radd), .psumctrl_rden(rden), .psumctrl_odat(odat),
    .psumctrl_ovld(ovld), .psumctrl_wadd(wadd), .psumctrl_wren(wren),
    .psumctrl_wdat(wdat), .busy(busy), .err_ovld(err));

  psum_accum_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PEND_DEPTH(DEPTH),
                    .PEND_WIDTH(2), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_psum(in_psum), .in_addr(in_addr),
    .in_first(in_first), .in_vld(in_vld), .in_rdy(w1_rdy),
    .psumctrl_radd(w1_radd), .psumctrl_rden(w1_rden), .psumctrl_odat(odat),
    .psumctrl_ovld(ovld), .psumctrl_wadd(w1_wadd), .psumctrl_wren(w1_wren),
    .psumctrl_wdat(w1_wdat), .busy(w1_busy), .err_ovld(w1_err));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] add_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input bit sat);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (sat && s > 64'sh7FFF_FFFF)  s = 64'sh7FFF_FFFF;
    if (sat && s < -64'sh8000_0000) s = -64'sh8000_0000;
    return s[DW-1:0];
  endfunction

  // ---------------- decoder / memory responder ----------------
  logic [DW-1:0] mem  [logic [AW-1:0]];
  logic [DW-1:0] wmem [logic [AW-1:0]];
  logic [AW-1:0] rq [$];
  bit hold = 0;
  bit inj  = 0;

  initial begin
    ovld = 1'b0;
    odat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rq.delete();
      end else begin
        if (rden) rq.push_back(radd);
        if (wren) mem[wadd] = wdat;
        if (w1_wren) wmem[w1_wadd] = w1_wdat;
      end
      @(posedge clk);
      #1;
      ovld = 1'b0;
      if (rst_n && !hold && rq.size() > 0) begin
        ovld = 1'b1;
        odat = mem[rq.pop_front()];
      end
      if (inj) ovld = 1'b1;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] psum;
  } ent_t;

  initial begin
    ent_t mq [$];
    ent_t h;
    logic          e_rden, e_wren, e_err;
    logic [AW-1:0] e_radd, e_wadd;
    logic [DW-1:0] e_wdat, e_wdat_wrap;
    logic          e_rdy, acc, fst, pop;
    e_rden = 0; e_wren = 0; e_err = 0;
    e_radd = '0; e_wadd = '0; e_wdat = '0; e_wdat_wrap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        e_rden = 0; e_wren = 0; e_err = 0;
        e_radd = '0; e_wadd = '0; e_wdat = '0; e_wdat_wrap = '0;
        chk("rst_rden", rden, 0);
        chk("rst_wren", wren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_radd", radd, 0);
        chk("rst_wadd", wadd, 0);
        chk("rst_wdat", wdat, 0);
      end else begin
        e_rdy = 1'b1;
        if (in_first) begin
          e_rdy = (mq.size() == 0);
        end else begin
          if (mq.size() >= DEPTH) e_rdy = 1'b0;
          foreach (mq[k]) if (mq[k].addr == in_addr) e_rdy = 1'b0;
        end
        chk("in_rdy", in_rdy, e_rdy);
        chk("rden", rden, e_rden);
        chk("radd", radd, e_radd);
        chk("wren", wren, e_wren);
        chk("wadd", wadd, e_wadd);
        chk("wdat", wdat, e_wdat);
        chk("busy", busy, (mq.size() != 0) || e_rden || e_wren);
        chk("err_ovld", err, e_err);
        chk("wrap_wren", w1_wren, e_wren);
        chk("wrap_wdat", w1_wdat, e_wdat_wrap);

        acc = in_vld && e_rdy && !in_first;
        fst = in_vld && e_rdy && in_first;
        pop = ovld && (mq.size() > 0);
        if (ovld && mq.size() == 0) e_err = 1'b1;
        e_rden = acc;
        if (acc) e_radd = in_addr;
        e_wren = fst || pop;
        if (fst) begin
          e_wadd = in_addr;
          e_wdat = in_psum;
          e_wdat_wrap = in_psum;
        end else if (pop) begin
          h = mq.pop_front();
          e_wadd = h.addr;
          e_wdat = add_model(odat, h.psum, 1'b1);
          e_wdat_wrap = add_model(odat, h.psum, 1'b0);
        end
        if (acc) mq.push_back('{addr: in_addr, psum: in_psum});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (in_rdy) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic send(input logic first, input logic [AW-1:0] a, input logic [DW-1:0] p);
    @(posedge clk);
    #1;
    in_vld = 1'b1; in_first = first; in_addr = a; in_psum = p;
    wait_accept();
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy && rq.size() == 0 && !ovld) break;
      n++;
      if (n > 200) begin
        chk("idle_timeout", 1, 0);
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_vld = 1'b0; in_first = 1'b0; in_addr = '0; in_psum = '0;
    mem[32'h10] = 32'd5;
    mem[32'h20] = 32'd1;
    mem[32'h0] = 32'd100; mem[32'h1] = 32'd200; mem[32'h2] = 32'd300; mem[32'h3] = 32'd400;
    mem[32'h4] = 32'd10;
    mem[32'h40] = 32'h7FFF_FFF0;
    mem[32'h44] = 32'h8000_0000;
    mem[32'h50] = 32'd0; mem[32'h54] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_wren", wren, 0);
    rst_n = 1'b1;

    // first-pass write
    send(1'b1, 32'h0000_8004, 32'd5);
    wait_idle();
    chk("first_mem", mem[32'h8004], 32'd5);

    // accumulate 5 + 7
    send(1'b0, 32'h10, 32'd7);
    wait_idle();
    chk("accum_mem", mem[32'h10], 32'd12);

    // read-after-write hazard on 0x20: 1 + 3 + 3
    send(1'b0, 32'h20, 32'd3);
    in_vld = 1'b1; in_first = 1'b0; in_addr = 32'h20; in_psum = 32'd3;
    @(negedge clk);
    chk("hazard_stall", in_rdy, 0);
    wait_accept();
    wait_idle();
    chk("hazard_mem", mem[32'h20], 32'd7);

    // queue full with read data withheld
    hold = 1;
    for (int i = 0; i < 4; i++) send(1'b0, 32'(i), 32'(i + 1));
    in_vld = 1'b1; in_first = 1'b0; in_addr = 32'h4; in_psum = 32'd5;
    repeat (3) begin
      @(negedge clk);
      chk("full_stall", in_rdy, 0);
      chk("full_busy", busy, 1);
    end
    hold = 0;
    wait_accept();
    wait_idle();
    chk("full_mem0", mem[32'h0], 32'd101);
    chk("full_mem1", mem[32'h1], 32'd202);
    chk("full_mem2", mem[32'h2], 32'd303);
    chk("full_mem3", mem[32'h3], 32'd404);
    chk("full_mem4", mem[32'h4], 32'd15);

    // saturation vs wrap-around
    send(1'b0, 32'h40, 32'h20);
    send(1'b0, 32'h44, 32'hFFFF_FFFF);
    wait_idle();
    chk("sat_pos", mem[32'h40], 32'h7FFF_FFFF);
    chk("wrap_pos", wmem[32'h40], 32'h8000_0010);
    chk("sat_neg", mem[32'h44], 32'h8000_0000);
    chk("wrap_neg", wmem[32'h44], 32'h7FFF_FFFF);

    // asynchronous reset with two reads pending, then a stray ovld
    hold = 1;
    send(1'b0, 32'h50, 32'd1);
    send(1'b0, 32'h54, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rden", rden, 0);
    chk("async_wren", wren, 0);
    chk("async_busy", busy, 0);
    chk("async_radd", radd, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    hold = 0;
    inj = 1;
    @(negedge clk);
    inj = 0;
    repeat (4) begin
      @(negedge clk);
      chk("err_sticky", err, 1);
      chk("err_nowren", wren, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
